// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised serial pattern detector: state width,
// elaboration-time KMP transition function and output-mode constants.
package seq_det_pkg;

  localparam int MODE_MOORE = 0;
  localparam int MODE_MEALY = 1;
  localparam int MAX_LEN    = 16;

  function automatic int state_w(input int len);
    return $clog2(len + 1);
  endfunction

  // Longest pattern prefix that is a suffix of (prefix of length s) followed by b.
  // A full match without overlap restarts the search from the empty prefix.
  function automatic int next_state(input logic [MAX_LEN-1:0] pattern, input int len,
                                    input bit overlap, input int s, input logic b);
    logic [MAX_LEN:0] seq;
    logic [MAX_LEN:0] pre;
    logic [MAX_LEN:0] mask;
    int base;
    int result;
    base   = (s == len && !overlap) ? 0 : s;
    seq    = (({1'b0, pattern} >> (len - base)) << 1) | {{MAX_LEN{1'b0}}, b};
    result = 0;
    for (int k = 1; k <= len; k++) begin
      if (k <= base + 1) begin
        mask = ({{MAX_LEN{1'b0}}, 1'b1} << k) - 1'b1;
        pre  = {1'b0, pattern} >> (len - k);
        if ((seq & mask) == pre) result = k;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  count <= '0;
    else if (clr)               count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial MSB-first pattern detector with Moore/Mealy output, optional overlap
// and a saturating match counter; transitions are a table built at elaboration.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               MEALY   = MODE_MOORE,
  parameter int               CNT_W   = 8,
  localparam int              SW      = state_w(PAT_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             t,
  input  logic             clr_count,
  output logic             p,
  output logic [CNT_W-1:0] match_count,
  output logic [SW-1:0]    state_dbg
);

  localparam logic [SW-1:0] FULL = SW'(PAT_LEN);

  logic [SW-1:0] state, state_n, nxt;
  logic [SW-1:0] nxt_tbl [PAT_LEN+1][2];
  logic          valid_state, hit, match;

  for (genvar gs = 0; gs <= PAT_LEN; gs++) begin : g_state
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      localparam int NS = next_state(MAX_LEN'(PATTERN), PAT_LEN, OVERLAP, gs, 1'(gb));
      assign nxt_tbl[gs][gb] = SW'(NS);
    end
  end

  assign valid_state = (state <= FULL);

  always_comb begin
    nxt = '0;
    if (valid_state) nxt = nxt_tbl[state][t];
  end

  assign hit   = (nxt == FULL);
  assign match = in_valid & hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= '0;
    else       state <= state_n;
  end

  // Stray encodings are flushed even while the input is idle.
  always_comb begin
    state_n = state;
    if (!valid_state)  state_n = '0;
    else if (in_valid) state_n = nxt;
  end

  always_comb begin
    p = 1'b0;
    if (MEALY == MODE_MEALY) p = match;
    else                     p = (state == FULL);
  end

  assign state_dbg = state;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_count),
    .inc   (match),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: three detector builds (overlap Moore, non-overlap Moore,
// overlap Mealy with a 2-bit counter) fed from one shared stimulus bus.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic t = 1'b0;
  logic clr_count = 1'b0;

  logic       p_ov, p_no, p_me;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_me;
  logic [2:0] st_ov, st_no, st_me;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector_param dut_ov (
    .clk(clk), .reset(reset), .in_valid(in_valid), .t(t), .clr_count(clr_count),
    .p(p_ov), .match_count(cnt_ov), .state_dbg(st_ov)
  );

  seq_detector_param #(.OVERLAP(1'b0)) dut_no (
    .clk(clk), .reset(reset), .in_valid(in_valid), .t(t), .clr_count(clr_count),
    .p(p_no), .match_count(cnt_no), .state_dbg(st_no)
  );

  seq_detector_param #(.MEALY(1), .CNT_W(2)) dut_me (
    .clk(clk), .reset(reset), .in_valid(in_valid), .t(t), .clr_count(clr_count),
    .p(p_me), .match_count(cnt_me), .state_dbg(st_me)
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; t = 1'b0; clr_count = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Drive one input cycle at the falling edge, return just after the rising edge.
  task automatic step(input logic v, input logic b);
    @(negedge clk);
    in_valid = v; t = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (st_ov !== 3'd0) begin errors++; $display("FAIL reset_state_ov: got %0d expected 0", st_ov); end
    checks++; if (p_ov !== 1'b0) begin errors++; $display("FAIL reset_p_ov: got %b expected 0", p_ov); end
    checks++; if (cnt_ov !== 8'd0) begin errors++; $display("FAIL reset_cnt_ov: got %0d expected 0", cnt_ov); end
    checks++; if (st_no !== 3'd0 || p_no !== 1'b0) begin errors++; $display("FAIL reset_no: got st=%0d p=%b expected st=0 p=0", st_no, p_no); end
    checks++; if (cnt_me !== 2'd0 || p_me !== 1'b0) begin errors++; $display("FAIL reset_me: got cnt=%0d p=%b expected cnt=0 p=0", cnt_me, p_me); end
  endtask

  task automatic test_overlap();
    logic [6:0] bits;
    int exp_st [7];
    bits = 7'b1011011;
    exp_st = '{1, 2, 3, 4, 2, 3, 4};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, bits[6-i]);
      checks++; if (st_ov !== 3'(exp_st[i])) begin errors++; $display("FAIL overlap_state[%0d]: got %0d expected %0d", i, st_ov, exp_st[i]); end
      checks++; if (p_ov !== (exp_st[i] == 4)) begin errors++; $display("FAIL overlap_p[%0d]: got %b expected %b", i, p_ov, exp_st[i] == 4); end
    end
    checks++; if (cnt_ov !== 8'd2) begin errors++; $display("FAIL overlap_count: got %0d expected 2", cnt_ov); end
  endtask

  task automatic test_no_overlap();
    logic [6:0] bits;
    int exp_st [7];
    bits = 7'b1011011;
    exp_st = '{1, 2, 3, 4, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, bits[6-i]);
      checks++; if (st_no !== 3'(exp_st[i])) begin errors++; $display("FAIL noovl_state[%0d]: got %0d expected %0d", i, st_no, exp_st[i]); end
      checks++; if (p_no !== (exp_st[i] == 4)) begin errors++; $display("FAIL noovl_p[%0d]: got %b expected %b", i, p_no, exp_st[i] == 4); end
    end
    checks++; if (cnt_no !== 8'd1) begin errors++; $display("FAIL noovl_count: got %0d expected 1", cnt_no); end
  endtask

  task automatic test_failure_path();
    logic [4:0] bits;
    int exp_st [5];
    bits = 5'b11011;
    exp_st = '{1, 1, 2, 3, 4};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bits[4-i]);
      checks++; if (st_ov !== 3'(exp_st[i])) begin errors++; $display("FAIL fail_state[%0d]: got %0d expected %0d", i, st_ov, exp_st[i]); end
    end
    checks++; if (p_ov !== 1'b1) begin errors++; $display("FAIL fail_p: got %b expected 1", p_ov); end
    checks++; if (cnt_ov !== 8'd1) begin errors++; $display("FAIL fail_count: got %0d expected 1", cnt_ov); end
  endtask

  task automatic test_valid_gaps();
    logic [9:0] vs, bs;
    int exp_st [10];
    vs = 10'b1010010100;
    bs = 10'b1000010100;
    exp_st = '{1, 1, 2, 2, 2, 3, 3, 4, 4, 4};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(vs[9-i], bs[9-i]);
      checks++; if (st_ov !== 3'(exp_st[i])) begin errors++; $display("FAIL gap_state[%0d]: got %0d expected %0d", i, st_ov, exp_st[i]); end
      checks++; if (p_ov !== (exp_st[i] == 4)) begin errors++; $display("FAIL gap_p[%0d]: got %b expected %b", i, p_ov, exp_st[i] == 4); end
    end
    checks++; if (cnt_ov !== 8'd1) begin errors++; $display("FAIL gap_count: got %0d expected 1", cnt_ov); end
  endtask

  task automatic test_reset_mid();
    logic [5:0] bits;
    bits = 6'b101101;
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, bits[5-i]);
    checks++; if (st_ov !== 3'd3 || cnt_ov !== 8'd1) begin errors++; $display("FAIL mid_pre: got st=%0d cnt=%0d expected st=3 cnt=1", st_ov, cnt_ov); end
    #1 reset = 1'b1;
    #1;
    checks++; if (st_ov !== 3'd0) begin errors++; $display("FAIL mid_async_state: got %0d expected 0", st_ov); end
    checks++; if (p_ov !== 1'b0) begin errors++; $display("FAIL mid_async_p: got %b expected 0", p_ov); end
    checks++; if (cnt_ov !== 8'd0) begin errors++; $display("FAIL mid_async_count: got %0d expected 0", cnt_ov); end
    reset = 1'b0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    checks++; if (st_ov !== 3'd1 || p_ov !== 1'b0) begin errors++; $display("FAIL mid_after: got st=%0d p=%b expected st=1 p=0", st_ov, p_ov); end
    checks++; if (cnt_ov !== 8'd0) begin errors++; $display("FAIL mid_after_count: got %0d expected 0", cnt_ov); end
  endtask

  task automatic test_mealy_saturate();
    logic [15:0] bits;
    int m;
    logic exp_p;
    bits = 16'b1011011011011011;
    m = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1; t = bits[15-i];
      #1;
      exp_p = (i >= 3) && (i % 3 == 0);
      checks++; if (p_me !== exp_p) begin errors++; $display("FAIL mealy_p[%0d]: got %b expected %b", i, p_me, exp_p); end
      if (exp_p) m++;
      @(posedge clk);
      #1;
      checks++; if (cnt_me !== 2'((m > 3) ? 3 : m)) begin errors++; $display("FAIL mealy_count[%0d]: got %0d expected %0d", i, cnt_me, (m > 3) ? 3 : m); end
    end
    step(1'b0, 1'b1);
    checks++; if (p_me !== 1'b0 || st_me !== 3'd4) begin errors++; $display("FAIL mealy_idle: got p=%b st=%0d expected p=0 st=4", p_me, st_me); end
  endtask

  task automatic test_clr_with_match();
    // dut_me sits in state 4 with count 3 from the previous test
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++; if (st_me !== 3'd3) begin errors++; $display("FAIL clr_pre_state: got %0d expected 3", st_me); end
    @(negedge clk);
    in_valid = 1'b1; t = 1'b1; clr_count = 1'b1;
    #1;
    checks++; if (p_me !== 1'b1) begin errors++; $display("FAIL clr_p: got %b expected 1", p_me); end
    @(posedge clk);
    #1;
    checks++; if (cnt_me !== 2'd0) begin errors++; $display("FAIL clr_count: got %0d expected 0", cnt_me); end
    checks++; if (st_me !== 3'd4) begin errors++; $display("FAIL clr_state: got %0d expected 4", st_me); end
    @(negedge clk);
    clr_count = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_failure_path();
    test_valid_gaps();
    test_reset_mid();
    test_mealy_saturate();
    test_clr_with_match();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
